win_banner_sequencer: RTL and testbench
=======================================

# win_banner_sequencer

Frame-synchronous controller that sequences the end-of-round "winner" banner overlay. On a game-over event it latches the winning player and drives the 3-bit banner-select code consumed by the win-banner address translator: codes 2–5 for players 0–3, code 0 for none. It blinks the banner for a fixed number of half-periods, then holds it steady. It then waits for a continue key and issues a one-cycle restart pulse to the game FSM. It sits between the game logic and the VGA overlay path, and changes the select code only on frame boundaries so no frame tears.

## Interface
- BLINK_FRAMES, 15, frame ticks per blink half-period (≥1)
- BLINK_TOGGLES, 6, number of visibility toggles in the blink phase (≥1)
- HOLD_FRAMES, 180, frame ticks of steady display before a key is accepted (≥1)
- clk  input  1  system clock (50 MHz)
- reset_n  input  1  asynchronous reset, active low
- frame_tick  input  1  one-cycle pulse per frame (start of vblank)
- game_over  input  1  one-cycle pulse; round ended
- winner  input  2  winning player index, sampled when game_over is accepted
- continue_key  input  1  one-cycle debounced key pulse
- win_start  output  3  banner select to translator: 0 = hidden, else 2 + latched winner
- banner_active  output  1  high from game_over acceptance until the restart pulse
- restart  output  1  one-cycle pulse requesting a new round

## Operation
- States: IDLE, ARM, BLINK, HOLD, WAIT_KEY, RESTART. All outputs are registered.
- IDLE:
  - win_start=0, banner_active=0.
  - game_over=1 latches winner into code_q = {1'b0,winner}+3'd2 (range 2..5) and moves to ARM.
- ARM:
  - banner_active=1, win_start stays 0.
  - On the next frame_tick: go to BLINK, set vis=1, clear frame_cnt and toggle_cnt.
  - A frame_tick in the same cycle as the game_over acceptance is not counted.
- BLINK:
  - Each frame_tick increments frame_cnt.
  - When frame_cnt reaches BLINK_FRAMES-1 on a tick: frame_cnt→0, vis toggles, toggle_cnt increments.
  - On the tick that completes toggle BLINK_TOGGLES: go to HOLD, force vis=1, clear frame_cnt.
- HOLD:
  - vis=1. Count frame_ticks.
  - On the tick where frame_cnt reaches HOLD_FRAMES-1: go to WAIT_KEY.
- WAIT_KEY:
  - vis=1. continue_key=1 moves to RESTART.
- RESTART:
  - restart=1 for exactly one cycle; win_start→0, banner_active→0.
  - Returns to IDLE on the next cycle.
- win_start = vis ? code_q : 3'd0, registered. It changes only on the cycle following a frame_tick, except the clear in RESTART.
- Ignored inputs:
  - continue_key is ignored outside WAIT_KEY.
  - game_over is ignored outside IDLE; winner is never re-sampled mid-sequence.
- Counters:
  - frame_cnt width = $clog2(max(BLINK_FRAMES,HOLD_FRAMES)+1).
  - toggle_cnt width = $clog2(BLINK_TOGGLES+1).
  - Counters never wrap within a state; comparisons are equality against parameter-1.
- Even BLINK_TOGGLES leaves vis=1 on entry to HOLD with no visible glitch; odd values rely on the forced vis=1.
- Reset (asynchronous, any state):
  - state=IDLE; all counters 0; code_q=0; vis=0.
  - win_start=0, banner_active=0, restart=0.
  - Release mid-sequence restarts cleanly in IDLE with no restart pulse.

## Timing
- game_over accepted at edge N → banner_active=1 at N+1.
- First frame_tick at edge F>N → win_start=code_q at F+1.
- Blink phase length: BLINK_TOGGLES×BLINK_FRAMES frame ticks.
- Hold phase length: HOLD_FRAMES frame ticks.
- continue_key at edge K in WAIT_KEY → restart=1 during cycle K+1 → win_start=0 and banner_active=0 at K+2.
- A new game_over is accepted no earlier than K+2.
- frame_tick and continue_key in the same cycle in WAIT_KEY: the key wins and the tick is irrelevant.

## Test plan
Benches use BLINK_FRAMES=2, BLINK_TOGGLES=4, HOLD_FRAMES=3, frame_tick every 10 cycles.
- Reset: reset_n low mid-BLINK → next cycle win_start=0, banner_active=0, restart=0; after release, state is IDLE.
- Full sequence, winner=2'd1:
  - win_start is 0 until the first tick after game_over, then 3'd3.
  - It toggles 3,0,3,0 every 2 ticks, then holds 3 for 3 ticks.
  - continue_key → restart high exactly 1 cycle, then win_start=0.
- Winner mapping: winner 0/1/2/3 → win_start 2/3/4/5 on first visible frame.
- Ignored events:
  - game_over with winner=3 during HOLD → code unchanged.
  - continue_key during BLINK/HOLD → no restart.
- Same-cycle collisions:
  - game_over coincident with frame_tick → win_start stays 0 until the following tick.
  - continue_key coincident with frame_tick in WAIT_KEY → restart issued.
- Back-to-back: game_over pulsed the cycle after restart → accepted; new code latched.

Source files
------------

// File: rtl/win_banner_sequencer.sv
// Winner banner overlay sequencer: latches the winner on game over, blinks the
// banner on frame boundaries, holds it steady, then waits for a key to restart.
module win_banner_sequencer #(
    parameter int BLINK_FRAMES  = 15,
    parameter int BLINK_TOGGLES = 6,
    parameter int HOLD_FRAMES   = 180
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       game_over,
    input  logic [1:0] winner,
    input  logic       continue_key,
    output logic [2:0] win_start,
    output logic       banner_active,
    output logic       restart
);

    localparam int FRAME_MAX = (BLINK_FRAMES > HOLD_FRAMES) ? BLINK_FRAMES : HOLD_FRAMES;
    localparam int FCW       = $clog2(FRAME_MAX + 1);
    localparam int TCW       = $clog2(BLINK_TOGGLES + 1);

    localparam logic [FCW-1:0] BLINK_LAST  = FCW'(BLINK_FRAMES - 1);
    localparam logic [FCW-1:0] HOLD_LAST   = FCW'(HOLD_FRAMES - 1);
    localparam logic [TCW-1:0] TOGGLE_LAST = TCW'(BLINK_TOGGLES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARM      = 3'd1,
        BLINK    = 3'd2,
        HOLD     = 3'd3,
        WAIT_KEY = 3'd4,
        RESTART  = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     code_q, code_d;
    logic           vis_q, vis_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic [TCW-1:0] toggle_cnt_q, toggle_cnt_d;
    logic [2:0]     win_start_q, win_start_d;
    logic           banner_q, banner_d;
    logic           restart_q, restart_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            code_q       <= 3'd0;
            vis_q        <= 1'b0;
            frame_cnt_q  <= '0;
            toggle_cnt_q <= '0;
            win_start_q  <= 3'd0;
            banner_q     <= 1'b0;
            restart_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            vis_q        <= vis_d;
            frame_cnt_q  <= frame_cnt_d;
            toggle_cnt_q <= toggle_cnt_d;
            win_start_q  <= win_start_d;
            banner_q     <= banner_d;
            restart_q    <= restart_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        vis_d        = vis_q;
        frame_cnt_d  = frame_cnt_q;
        toggle_cnt_d = toggle_cnt_q;
        win_start_d  = win_start_q;
        banner_d     = banner_q;
        restart_d    = 1'b0;

        case (state_q)
            IDLE: begin
                banner_d    = 1'b0;
                win_start_d = 3'd0;
                // A frame_tick coincident with acceptance is deliberately not counted.
                if (game_over) begin
                    code_d   = {1'b0, winner} + 3'd2;
                    banner_d = 1'b1;
                    state_d  = ARM;
                end
            end
            ARM: begin
                if (frame_tick) begin
                    state_d      = BLINK;
                    vis_d        = 1'b1;
                    frame_cnt_d  = '0;
                    toggle_cnt_d = '0;
                end
            end
            BLINK: begin
                if (frame_tick) begin
                    if (frame_cnt_q == BLINK_LAST) begin
                        frame_cnt_d  = '0;
                        vis_d        = ~vis_q;
                        toggle_cnt_d = toggle_cnt_q + TCW'(1);
                        // Odd toggle counts would end hidden; force visible for the hold.
                        if (toggle_cnt_q == TOGGLE_LAST) begin
                            state_d = HOLD;
                            vis_d   = 1'b1;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + FCW'(1);
                    end
                end
            end
            HOLD: begin
                vis_d = 1'b1;
                if (frame_tick) begin
                    if (frame_cnt_q == HOLD_LAST) begin
                        state_d = WAIT_KEY;
                    end else begin
                        frame_cnt_d = frame_cnt_q + FCW'(1);
                    end
                end
            end
            WAIT_KEY: begin
                vis_d = 1'b1;
                if (continue_key) begin
                    state_d   = RESTART;
                    restart_d = 1'b1;
                end
            end
            RESTART: begin
                state_d      = IDLE;
                vis_d        = 1'b0;
                frame_cnt_d  = '0;
                toggle_cnt_d = '0;
                win_start_d  = 3'd0;
                banner_d     = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The select code only moves on frame boundaries so a frame never tears.
        if (frame_tick && (state_q inside {ARM, BLINK, HOLD, WAIT_KEY})) begin
            win_start_d = vis_d ? code_d : 3'd0;
        end
    end

    assign win_start     = win_start_q;
    assign banner_active = banner_q;
    assign restart       = restart_q;

endmodule

// File: tb/tb_win_banner_sequencer.sv
// Scoreboard bench for win_banner_sequencer: stimulus queues expected output
// events (kind, value, cycle); a negedge monitor pops and compares them.
module tb_win_banner_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       frame_tick;
    logic       game_over;
    logic [1:0] winner;
    logic       continue_key;
    logic [2:0] win_start;
    logic       banner_active;
    logic       restart;

    win_banner_sequencer #(
        .BLINK_FRAMES (2),
        .BLINK_TOGGLES(4),
        .HOLD_FRAMES  (3)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .frame_tick   (frame_tick),
        .game_over    (game_over),
        .winner       (winner),
        .continue_key (continue_key),
        .win_start    (win_start),
        .banner_active(banner_active),
        .restart      (restart)
    );

    always #5 clk = ~clk;

    localparam int EV_RS = 0;
    localparam int EV_BA = 1;
    localparam int EV_WS = 2;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } ev_t;

    ev_t  exp_q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   tph = 0;
    bit   mon_en = 1'b0;
    logic [2:0] ws_prev = 3'd0;
    logic       ba_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        if (k == EV_RS) return "restart";
        if (k == EV_BA) return "banner_active";
        return "win_start";
    endfunction

    task automatic expect_ev(input int k, input int v, input int c);
        ev_t e;
        e.kind = k;
        e.val  = v;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int k, input int v);
        ev_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL event: got %s=%0d at cycle %0d, required no event", kname(k), v, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v || e.cyc != cyc) begin
                miscompares++;
                $display("FAIL event: got %s=%0d at cycle %0d, required %s=%0d at cycle %0d",
                         kname(k), v, cyc, kname(e.kind), e.val, e.cyc);
            end
        end
    endtask

    task automatic check_val(input string name, input int got, input int req);
        vectors++;
        if (got != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    // Monitor: every output change (and every restart-high cycle) is an event.
    always @(negedge clk) begin
        if (mon_en) begin
            if (restart) check_ev(EV_RS, 1);
            if (banner_active !== ba_prev) check_ev(EV_BA, int'(banner_active));
            if (win_start !== ws_prev) check_ev(EV_WS, int'(win_start));
        end
        ba_prev = banner_active;
        ws_prev = win_start;
    end

    // One clock of stimulus; frame_tick fires every 10 cycles on phase 0.
    task automatic step(input bit go, input logic [1:0] w, input bit key, output bit tick_o);
        frame_tick   = (tph == 0);
        game_over    = go;
        winner       = w;
        continue_key = key;
        tick_o       = frame_tick;
        @(posedge clk);
        #1;
        tph          = (tph == 9) ? 0 : tph + 1;
        frame_tick   = 1'b0;
        game_over    = 1'b0;
        continue_key = 1'b0;
    endtask

    // Hand-derived visibility after each tick for BLINK_FRAMES=2, BLINK_TOGGLES=4.
    function automatic bit vis_at(input int n);
        bit pat [9];
        pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        if (n < 9) return pat[n];
        return 1'b1;
    endfunction

    task automatic run_full(input logic [1:0] w, input int code, input bit go_on_tick,
                            input bit key_on_tick, input bit inject);
        bit t;
        bit shown;
        bit v;
        bit go;
        bit key;
        logic [1:0] wv;
        int n;
        if (go_on_tick) begin
            while (tph != 0) step(1'b0, w, 1'b0, t);
        end
        step(1'b1, w, 1'b0, t);
        expect_ev(EV_BA, 1, cyc);
        n = 0;
        shown = 1'b0;
        while (n < 12) begin
            go  = 1'b0;
            key = 1'b0;
            wv  = w;
            if (inject && tph != 0) begin
                if (n == 3 && tph == 5) key = 1'b1;
                if (n == 10 && tph == 3) begin
                    go = 1'b1;
                    wv = 2'd3;
                end
                if (n == 10 && tph == 6) key = 1'b1;
            end
            step(go, wv, key, t);
            if (t) begin
                v = vis_at(n);
                if (v != shown) expect_ev(EV_WS, v ? code : 0, cyc);
                shown = v;
                n++;
            end
        end
        if (key_on_tick) begin
            while (tph != 0) step(1'b0, w, 1'b0, t);
        end else begin
            step(1'b0, w, 1'b0, t);
            step(1'b0, w, 1'b0, t);
        end
        step(1'b0, w, 1'b1, t);
        expect_ev(EV_RS, 1, cyc);
        expect_ev(EV_BA, 0, cyc + 1);
        expect_ev(EV_WS, 0, cyc + 1);
        step(1'b0, w, 1'b0, t);
    endtask

    task automatic reset_mid_blink();
        bit t;
        int n;
        step(1'b1, 2'd1, 1'b0, t);
        n = 0;
        while (n < 5) begin
            step(1'b0, 2'd1, 1'b0, t);
            if (t) n++;
        end
        check_val("pre_reset_banner_active", int'(banner_active), 1);
        check_val("pre_reset_win_start", int'(win_start), 3);
        #2;
        reset_n = 1'b0;
        @(negedge clk);
        check_val("reset_win_start", int'(win_start), 0);
        check_val("reset_banner_active", int'(banner_active), 0);
        check_val("reset_restart", int'(restart), 0);
        @(posedge clk);
        #1;
        tph = (tph == 9) ? 0 : tph + 1;
        step(1'b0, 2'd0, 1'b0, t);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'd0, 1'b0, t);
            check_val("post_reset_restart", int'(restart), 0);
            check_val("post_reset_banner_active", int'(banner_active), 0);
            check_val("post_reset_win_start", int'(win_start), 0);
        end
    endtask

    initial begin
        bit t;
        reset_n      = 1'b0;
        frame_tick   = 1'b0;
        game_over    = 1'b0;
        winner       = 2'd0;
        continue_key = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("init_win_start", int'(win_start), 0);
        check_val("init_banner_active", int'(banner_active), 0);
        check_val("init_restart", int'(restart), 0);
        reset_n = 1'b1;
        tph = 0;

        reset_mid_blink();
        mon_en = 1'b1;

        run_full(2'd1, 3, 1'b0, 1'b0, 1'b1);
        run_full(2'd0, 2, 1'b1, 1'b1, 1'b0);
        run_full(2'd2, 4, 1'b0, 1'b0, 1'b0);
        run_full(2'd3, 5, 1'b0, 1'b0, 1'b0);

        repeat (5) step(1'b0, 2'd0, 1'b0, t);
        check_val("pending_expected_events", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, got cycle %0d, required completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
